// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (g..a), special
// codes and the scan-decoder state type. The display encoder uses the same constants.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BLANK_CODE = 4'hE;
   localparam logic [3:0] BAD_CODE   = 4'hF;

   typedef enum logic [1:0] {
      WAIT_SEL,
      SETTLE,
      CAPTURED
   } scan_state_t;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] one_hot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (v[i]) idx = i[1:0];
      return idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low g..a pattern to a digit code.
// valid = recognised digit 0-9; blank = all segments off.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       valid,
   output logic       blank
);

   always_comb begin
      code  = BAD_CODE;
      valid = 1'b1;
      blank = 1'b0;
      case (pattern)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: begin
            code  = BLANK_CODE;
            valid = 1'b0;
            blank = 1'b1;
         end
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a scanned 7-segment bus: debounces each digit dwell,
// decodes it and publishes complete 4-digit frames.
module seven_seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  segment_display,
   input  logic [3:0]  digit_select,
   output logic [15:0] digits,
   output logic [3:0]  dp_flags,
   output logic        frame_valid,
   output logic        frame_changed,
   output logic        pattern_error,
   output logic        scan_stall
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [3:0]    sel_q, sel_p;
   logic [7:0]    seg_q, seg_p;
   scan_state_t   state, state_n;
   logic [SW-1:0] stab_cnt, stab_cnt_n;
   logic [TW-1:0] stall_cnt;
   logic          capture;
   logic          pair_chg;
   logic          sel_one_hot;
   logic [1:0]    sel_idx;
   logic [3:0]    dec_code;
   logic          dec_valid, dec_blank;
   logic [3:0]    mask;
   logic [15:0]   shadow_code;
   logic [3:0]    shadow_dp;
   logic          seen_frame;

   // Previous registered pair is kept so "stable" means identical consecutive samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= '0;
         sel_p <= '0;
         seg_q <= '0;
         seg_p <= '0;
      end else begin
         sel_q <= SEL_ACTIVE_LOW ? ~digit_select : digit_select;
         seg_q <= segment_display;
         sel_p <= sel_q;
         seg_p <= seg_q;
      end
   end

   assign pair_chg    = (sel_q != sel_p) || (seg_q != seg_p);
   assign sel_one_hot = is_one_hot(sel_q);
   assign sel_idx     = one_hot_idx(sel_q);

   seg7_pattern_decode u_decode (
      .pattern (seg_q[6:0]),
      .code    (dec_code),
      .valid   (dec_valid),
      .blank   (dec_blank)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= WAIT_SEL;
         stab_cnt <= '0;
      end else begin
         state    <= state_n;
         stab_cnt <= stab_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      stab_cnt_n = stab_cnt;
      capture    = 1'b0;
      case (state)
         WAIT_SEL: begin
            if (sel_one_hot) begin
               state_n    = SETTLE;
               stab_cnt_n = SW'(1);
            end
         end
         SETTLE: begin
            if (pair_chg) begin
               state_n    = sel_one_hot ? SETTLE : WAIT_SEL;
               stab_cnt_n = sel_one_hot ? SW'(1) : '0;
            end else begin
               stab_cnt_n = stab_cnt + SW'(1);
               // This sample makes STABLE_CYCLES identical in a row.
               if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
                  capture = 1'b1;
                  state_n = CAPTURED;
               end
            end
         end
         CAPTURED: begin
            if (pair_chg) begin
               state_n    = sel_one_hot ? SETTLE : WAIT_SEL;
               stab_cnt_n = sel_one_hot ? SW'(1) : '0;
            end
         end
         default: begin
            state_n    = WAIT_SEL;
            stab_cnt_n = '0;
         end
      endcase
   end

   // Frame publishes one edge after the last mask bit is set; capture can't coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask          <= '0;
         shadow_code   <= '0;
         shadow_dp     <= '0;
         digits        <= '0;
         dp_flags      <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         pattern_error <= 1'b0;
         seen_frame    <= 1'b0;
      end else begin
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         pattern_error <= 1'b0;
         if (mask == 4'hF) begin
            digits        <= shadow_code;
            dp_flags      <= shadow_dp;
            frame_valid   <= 1'b1;
            frame_changed <= !seen_frame ||
                             ({shadow_code, shadow_dp} != {digits, dp_flags});
            seen_frame    <= 1'b1;
            mask          <= '0;
         end
         if (capture) begin
            shadow_code[{sel_idx, 2'b00} +: 4] <= dec_code;
            shadow_dp[sel_idx]                 <= ~seg_q[7];
            mask[sel_idx]                      <= 1'b1;
            pattern_error                      <= !dec_valid && !dec_blank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (sel_q != sel_p)
         stall_cnt <= '0;
      else if (stall_cnt != TW'(TIMEOUT_CYCLES))
         stall_cnt <= stall_cnt + TW'(1);
   end

   assign scan_stall = (stall_cnt >= TW'(TIMEOUT_CYCLES));

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side decoder for the multiplexed 7-segment display bus driven by Display_module (segment_display / digit_select). Samples the scanned bus, rejects transition glitches, decodes each active-low segment pattern back to a 4-bit digit code and assembles complete 4-digit frames. Used as a loopback checker on the display output and as a reusable bus monitor in system-level benches and FPGA self-test.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples of (digit_select, segment_display) required before a digit is captured; minimum 2.
TIMEOUT_CYCLES, 4096, cycles without a digit_select change before scan_stall asserts.
SEL_ACTIVE_LOW, 1, 1: digit_select is one-hot active-low; 0: one-hot active-high.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
segment_display  input  8  active-low segments: bit7 = dp, bits6:0 = g..a.
digit_select  input  4  one-hot digit enable; bit0 = least significant digit.
digits  output  16  last complete frame, nibble n = digit n code.
dp_flags  output  4  last complete frame decimal points, 1 = dp lit.
frame_valid  output  1  1-cycle pulse when digits/dp_flags update.
frame_changed  output  1  1-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one (first frame after reset always counts as changed).
pattern_error  output  1  1-cycle pulse on capture of an unrecognised pattern.
scan_stall  output  1  level, digit_select static for TIMEOUT_CYCLES.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port reset.
- Reset: digits=0, dp_flags=0, frame_valid=0, frame_changed=0, pattern_error=0, scan_stall=0; FSM to WAIT_SEL; capture mask, shadow registers and counters cleared. Reset mid-frame discards partial captures.
- Input stage: both buses registered once (1-cycle latency); select normalised to active-high internally.
- Decode on bits6:0 (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 -> 0..9; 1111111 (blank) -> 4'hE, no error; any other -> 4'hF plus pattern_error pulse. dp = ~bit7.
- FSM states:
  WAIT_SEL: normalised select not exactly one-hot. Go to SETTLE when it is one-hot; stable counter loads 1.
  SETTLE: counter increments while the registered pair equals its previous value; any change restarts the count (stays in SETTLE if still one-hot, else WAIT_SEL). When the count reaches STABLE_CYCLES: write decoded code and dp into shadow slot of the selected position, set that mask bit, go to CAPTURED.
  CAPTURED: hold; no recapture of the same dwell. Any change of select or segments -> WAIT_SEL or SETTLE per one-hot rule.
- Frame completion: on the edge that sets the last mask bit (mask becomes 1111), copy shadow to digits/dp_flags on the next edge with frame_valid=1, frame_changed per comparison; mask clears. Recapturing an already-set position before completion overwrites its shadow slot, mask unchanged.
- Zero/multi-hot select never captures; zero select for extended time still drives stall counting.
- scan_stall: counter resets on every change of registered select, saturates; scan_stall=1 while count >= TIMEOUT_CYCLES; clears the cycle after the next select change. Stall does not clear mask.
- Counter widths: $clog2(STABLE_CYCLES+1), $clog2(TIMEOUT_CYCLES+1); no wrap.

Decomposition:
- Shared package seg7_pkg: segment pattern constants 0-9 and blank, BLANK_CODE=4'hE, BAD_CODE=4'hF, FSM state typedef (WAIT_SEL, SETTLE, CAPTURED). Display_module encoder reuses the same constants.
- One sub-module: seg7_pattern_decode (combinational 7-bit pattern -> 4-bit code + valid + blank flags).

Test Plan:
- Reset held 3 cycles with bus active -> all outputs 0, no frame_valid for the following 3 cycles.
- Scan digits 0,0,5,8 (sel 1110,1101,1011,0111; seg C0,C0,92,80) 100-cycle dwell -> one frame_valid with digits=16'h8500, frame_changed=1; identical second scan -> frame_valid=1, frame_changed=0.
- Glitch: one select held 2 cycles between valid dwells -> not captured, mask unchanged, no pattern_error.
- Digit 2 driven 8'hFF, digit 3 driven 8'h55 in a full scan -> digits[11:8]=E, digits[15:12]=F, exactly one pattern_error pulse.
- Select frozen 4096 cycles -> scan_stall=1 at cycle 4096+1; scanning resumes -> scan_stall=0 one cycle after first select change.
- Reset after 2 of 4 digits captured, then full scan 1,2,3,4 -> single frame_valid, digits=16'h4321, no stale nibbles.
